// File: rtl/ao486_l15_req_arbiter_if.sv
// Requester channel between one ao486 transducer front end and the L1.5 request arbiter.
// The requester holds req_val and its fields stable until req_ready pulses.
interface ao486_l15_req_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 40
);
    logic                  req_val;
    logic [4:0]            req_rqtype;
    logic [2:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [63:0]           req_data;
    logic                  req_nc;
    logic                  req_ready;
    logic                  resp_val;

    modport master (
        output req_val, req_rqtype, req_size, req_addr, req_data, req_nc,
        input  req_ready, resp_val
    );

    modport slave (
        input  req_val, req_rqtype, req_size, req_addr, req_data, req_nc,
        output req_ready, resp_val
    );
endinterface

// File: rtl/ao486_l15_req_arbiter.sv
// Round-robin arbiter sharing the L1.5 request/response port between the ao486 mem and io
// front ends; one outstanding transaction, INT_RET bypasses the FSM.
module ao486_l15_req_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 40,
    parameter int unsigned RESP_TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ao486_l15_req_arbiter_if.slave  mem_if,
    ao486_l15_req_arbiter_if.slave  io_if,
    output logic                    transducer_l15_val_o,
    output logic [4:0]              transducer_l15_rqtype_o,
    output logic [2:0]              transducer_l15_size_o,
    output logic [ADDR_WIDTH-1:0]   transducer_l15_address_o,
    output logic [63:0]             transducer_l15_data_o,
    output logic                    transducer_l15_nc_o,
    input  logic                    l15_transducer_header_ack_i,
    input  logic                    l15_transducer_val_i,
    input  logic [3:0]              l15_transducer_returntype_i,
    input  logic [63:0]             l15_transducer_data_0_i,
    input  logic [63:0]             l15_transducer_data_1_i,
    output logic                    transducer_l15_req_ack_o,
    output logic [63:0]             resp_data_0_o,
    output logic [63:0]             resp_data_1_o,
    output logic                    int_val_o,
    output logic                    timeout_err_o,
    output logic                    spurious_err_o
);
    localparam logic [3:0] LoadRet = 4'b0000;
    localparam logic [3:0] StAck   = 4'b0100;
    localparam logic [3:0] IntRet  = 4'b0111;

    localparam int unsigned   WdW   = (RESP_TIMEOUT < 1) ? 1 : $clog2(RESP_TIMEOUT + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(RESP_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                state_q;
    logic                  owner_q;  // 0 = mem, 1 = io
    logic                  rr_q;
    logic [4:0]            rqtype_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [63:0]           data_q;
    logic                  nc_q;
    logic [WdW-1:0]        wd_q;
    logic                  timeout_q;
    logic                  spurious_q;

    logic grant, grant_io, rt_data, rt_int, resp_done;

    always_comb begin
        grant     = (state_q == StIdle) && (mem_if.req_val || io_if.req_val);
        // io wins when it is alone, or when both are valid and the pointer favours io
        grant_io  = io_if.req_val && (!mem_if.req_val || rr_q);
        rt_data   = (l15_transducer_returntype_i == LoadRet) ||
                    (l15_transducer_returntype_i == StAck);
        rt_int    = (l15_transducer_returntype_i == IntRet);
        resp_done = (state_q == StWait) && l15_transducer_val_i && rt_data;
    end

    assign mem_if.req_ready = grant && !grant_io;
    assign io_if.req_ready  = grant && grant_io;
    assign mem_if.resp_val  = resp_done && !owner_q;
    assign io_if.resp_val   = resp_done && owner_q;

    assign transducer_l15_val_o     = (state_q == StIssue);
    assign transducer_l15_rqtype_o  = rqtype_q;
    assign transducer_l15_size_o    = size_q;
    assign transducer_l15_address_o = addr_q;
    assign transducer_l15_data_o    = data_q;
    assign transducer_l15_nc_o      = nc_q;

    // Every response is consumed immediately, whether routed, signalled or dropped.
    assign transducer_l15_req_ack_o = l15_transducer_val_i;
    assign int_val_o      = l15_transducer_val_i && rt_int &&
                            (l15_transducer_data_0_i[17:16] == 2'b01);
    assign resp_data_0_o  = l15_transducer_data_0_i;
    assign resp_data_1_o  = l15_transducer_data_1_i;
    assign timeout_err_o  = timeout_q;
    assign spurious_err_o = spurious_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            rr_q       <= 1'b0;
            rqtype_q   <= '0;
            size_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            nc_q       <= 1'b0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        rqtype_q <= grant_io ? io_if.req_rqtype : mem_if.req_rqtype;
                        size_q   <= grant_io ? io_if.req_size   : mem_if.req_size;
                        addr_q   <= grant_io ? io_if.req_addr   : mem_if.req_addr;
                        data_q   <= grant_io ? io_if.req_data   : mem_if.req_data;
                        nc_q     <= grant_io ? io_if.req_nc     : mem_if.req_nc;
                        owner_q  <= grant_io;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    if (l15_transducer_header_ack_i) state_q <= StWait;
                end
                StWait: begin
                    if (resp_done) begin
                        state_q <= StIdle;
                        rr_q    <= !owner_q;
                        wd_q    <= '0;
                    end else if (wd_q != WdMax) begin
                        wd_q <= wd_q + WdW'(1);
                        if (wd_q == WdMax - WdW'(1)) timeout_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (l15_transducer_val_i && !rt_int && (state_q != StWait)) spurious_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ao486_l15_req_arbiter.sv
// Directed bench for ao486_l15_req_arbiter: arbitration, handshake timing, INT_RET bypass,
// watchdog, spurious responses and asynchronous reset.
module tb_ao486_l15_req_arbiter;
    localparam int unsigned AW = 40;
    localparam int unsigned TO = 16;

    localparam logic [3:0] LoadRet = 4'b0000;
    localparam logic [3:0] StAck   = 4'b0100;
    localparam logic [3:0] IntRet  = 4'b0111;
    localparam logic [3:0] OtherRt = 4'b0011;

    localparam logic [AW-1:0] MemAddr = 40'h80_0000_0040;
    localparam logic [AW-1:0] IoAddr  = 40'h00_0000_03f8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          l15_val_o;
    logic [4:0]    l15_rqtype_o;
    logic [2:0]    l15_size_o;
    logic [AW-1:0] l15_addr_o;
    logic [63:0]   l15_data_o;
    logic          l15_nc_o;
    logic          hdr_ack = 1'b0;
    logic          rsp_val = 1'b0;
    logic [3:0]    rsp_rt = 4'b0;
    logic [63:0]   rsp_d0 = '0;
    logic [63:0]   rsp_d1 = '0;
    logic          req_ack_o;
    logic [63:0]   resp_d0_o, resp_d1_o;
    logic          int_val_o, timeout_o, spurious_o;

    int n_tests = 0;
    int n_fail  = 0;

    ao486_l15_req_arbiter_if #(.ADDR_WIDTH(AW)) mem_if ();
    ao486_l15_req_arbiter_if #(.ADDR_WIDTH(AW)) io_if ();

    ao486_l15_req_arbiter #(.ADDR_WIDTH(AW), .RESP_TIMEOUT(TO)) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .mem_if                      (mem_if),
        .io_if                       (io_if),
        .transducer_l15_val_o        (l15_val_o),
        .transducer_l15_rqtype_o     (l15_rqtype_o),
        .transducer_l15_size_o       (l15_size_o),
        .transducer_l15_address_o    (l15_addr_o),
        .transducer_l15_data_o       (l15_data_o),
        .transducer_l15_nc_o         (l15_nc_o),
        .l15_transducer_header_ack_i (hdr_ack),
        .l15_transducer_val_i        (rsp_val),
        .l15_transducer_returntype_i (rsp_rt),
        .l15_transducer_data_0_i     (rsp_d0),
        .l15_transducer_data_1_i     (rsp_d1),
        .transducer_l15_req_ack_o    (req_ack_o),
        .resp_data_0_o               (resp_d0_o),
        .resp_data_1_o               (resp_d1_o),
        .int_val_o                   (int_val_o),
        .timeout_err_o               (timeout_o),
        .spurious_err_o              (spurious_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        mem_if.req_val = 1'b0; mem_if.req_rqtype = 5'd0; mem_if.req_size = 3'd3;
        mem_if.req_addr = MemAddr; mem_if.req_data = 64'h1111_2222_3333_4444; mem_if.req_nc = 1'b0;
        io_if.req_val = 1'b0; io_if.req_rqtype = 5'd1; io_if.req_size = 3'd0;
        io_if.req_addr = IoAddr; io_if.req_data = 64'h55; io_if.req_nc = 1'b1;
        hdr_ack = 1'b0; rsp_val = 1'b0; rsp_rt = LoadRet; rsp_d0 = '0; rsp_d1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic both_txn(input logic exp_io, input string tag);
        mem_if.req_val = 1'b1; io_if.req_val = 1'b1;
        settle();
        chk({tag, " mem_ready"}, 64'(mem_if.req_ready), 64'(!exp_io));
        chk({tag, " io_ready"}, 64'(io_if.req_ready), 64'(exp_io));
        step();
        hdr_ack = 1'b1;
        settle();
        chk({tag, " issue addr"}, 64'(l15_addr_o), 64'(exp_io ? IoAddr : MemAddr));
        chk({tag, " no ready in issue"}, 64'(mem_if.req_ready | io_if.req_ready), 64'd0);
        step();
        hdr_ack = 1'b0; rsp_val = 1'b1; rsp_rt = StAck;
        settle();
        chk({tag, " mem_resp"}, 64'(mem_if.resp_val), 64'(!exp_io));
        chk({tag, " io_resp"}, 64'(io_if.resp_val), 64'(exp_io));
        step();
        rsp_val = 1'b0;
    endtask

    initial begin
        // Reset state
        clear_inputs();
        #3;
        chk("rst l15_val", 64'(l15_val_o), 64'd0);
        chk("rst address", 64'(l15_addr_o), 64'd0);
        chk("rst timeout", 64'(timeout_o), 64'd0);
        chk("rst spurious", 64'(spurious_o), 64'd0);
        do_reset();

        // Mem only: cycle 0 grant, header_ack at 3, LOAD_RET at 6
        mem_if.req_val = 1'b1;
        settle();
        chk("t1 c0 mem_ready", 64'(mem_if.req_ready), 64'd1);
        chk("t1 c0 l15_val", 64'(l15_val_o), 64'd0);
        step();
        mem_if.req_val = 1'b0;
        settle();
        chk("t1 c1 l15_val", 64'(l15_val_o), 64'd1);
        chk("t1 c1 addr", 64'(l15_addr_o), 64'(MemAddr));
        chk("t1 c1 data", l15_data_o, 64'h1111_2222_3333_4444);
        step();
        step();
        hdr_ack = 1'b1;
        settle();
        chk("t1 c3 l15_val", 64'(l15_val_o), 64'd1);
        step();
        hdr_ack = 1'b0;
        settle();
        chk("t1 c4 l15_val", 64'(l15_val_o), 64'd0);
        step();
        step();
        rsp_val = 1'b1; rsp_rt = LoadRet; rsp_d0 = 64'hdead_beef_0123_4567;
        settle();
        chk("t1 c6 mem_resp", 64'(mem_if.resp_val), 64'd1);
        chk("t1 c6 io_resp", 64'(io_if.resp_val), 64'd0);
        chk("t1 c6 req_ack", 64'(req_ack_o), 64'd1);
        chk("t1 c6 resp_data_0", resp_d0_o, 64'hdead_beef_0123_4567);
        step();
        rsp_val = 1'b0;
        settle();
        chk("t1 c7 mem_resp", 64'(mem_if.resp_val), 64'd0);

        // Both valid from reset: mem, io, mem, io
        do_reset();
        both_txn(1'b0, "t2 #0");
        both_txn(1'b1, "t2 #1");
        both_txn(1'b0, "t2 #2");
        both_txn(1'b1, "t2 #3");
        mem_if.req_val = 1'b0; io_if.req_val = 1'b0;

        // INT_RET during WAIT of an io load
        do_reset();
        io_if.req_val = 1'b1;
        settle();
        chk("t3 io_ready", 64'(io_if.req_ready), 64'd1);
        step();
        io_if.req_val = 1'b0; hdr_ack = 1'b1;
        step();
        hdr_ack = 1'b0; rsp_val = 1'b1; rsp_rt = IntRet; rsp_d0 = 64'h0001_0000;
        settle();
        chk("t3 int_val", 64'(int_val_o), 64'd1);
        chk("t3 int req_ack", 64'(req_ack_o), 64'd1);
        chk("t3 int io_resp", 64'(io_if.resp_val), 64'd0);
        step();
        rsp_d0 = 64'h0002_0000;
        settle();
        chk("t3 int bad code", 64'(int_val_o), 64'd0);
        step();
        rsp_rt = OtherRt;
        settle();
        chk("t3 other ack", 64'(req_ack_o), 64'd1);
        chk("t3 other io_resp", 64'(io_if.resp_val), 64'd0);
        step();
        rsp_rt = LoadRet;
        settle();
        chk("t3 load io_resp", 64'(io_if.resp_val), 64'd1);
        chk("t3 load mem_resp", 64'(mem_if.resp_val), 64'd0);
        step();
        rsp_val = 1'b0;
        settle();
        chk("t3 no spurious", 64'(spurious_o), 64'd0);

        // Watchdog: timeout_err exactly TO cycles after entering WAIT
        do_reset();
        mem_if.req_val = 1'b1;
        step();
        mem_if.req_val = 1'b0; hdr_ack = 1'b1;
        step();
        hdr_ack = 1'b0;
        repeat (TO - 1) step();
        settle();
        chk("t4 before timeout", 64'(timeout_o), 64'd0);
        step();
        settle();
        chk("t4 at timeout", 64'(timeout_o), 64'd1);
        step();
        rsp_val = 1'b1; rsp_rt = StAck;
        settle();
        chk("t4 late st_ack mem_resp", 64'(mem_if.resp_val), 64'd1);
        step();
        rsp_val = 1'b0;
        settle();
        chk("t4 timeout sticky", 64'(timeout_o), 64'd1);

        // Reset in ISSUE (rr_ptr currently points at io)
        io_if.req_val = 1'b1;
        settle();
        chk("t6 io_ready", 64'(io_if.req_ready), 64'd1);
        step();
        io_if.req_val = 1'b0;
        settle();
        chk("t6 issue val", 64'(l15_val_o), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6 async val drop", 64'(l15_val_o), 64'd0);
        chk("t6 timeout cleared", 64'(timeout_o), 64'd0);
        step();
        rst_n = 1'b1;
        mem_if.req_val = 1'b1; io_if.req_val = 1'b1;
        settle();
        chk("t6 rr mem_ready", 64'(mem_if.req_ready), 64'd1);
        chk("t6 rr io_ready", 64'(io_if.req_ready), 64'd0);
        step();
        mem_if.req_val = 1'b0; io_if.req_val = 1'b0;
        rsp_val = 1'b1; rsp_rt = LoadRet;
        settle();
        chk("t6 issue resp mem", 64'(mem_if.resp_val), 64'd0);
        chk("t6 issue resp io", 64'(io_if.resp_val), 64'd0);
        step();
        rsp_val = 1'b0;
        settle();
        chk("t6 spurious", 64'(spurious_o), 64'd1);

        // ST_ACK while IDLE
        do_reset();
        rsp_val = 1'b1; rsp_rt = StAck;
        settle();
        chk("t5 req_ack", 64'(req_ack_o), 64'd1);
        chk("t5 mem_resp", 64'(mem_if.resp_val), 64'd0);
        chk("t5 io_resp", 64'(io_if.resp_val), 64'd0);
        step();
        rsp_val = 1'b0;
        settle();
        chk("t5 spurious", 64'(spurious_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ao486_l15_req_arbiter.md
Name: ao486_l15_req_arbiter

Overview:
Shares the single L1.5 request/response port between the ao486 memory-bus and io-bus transducer front ends.
Grants one requester at a time using round-robin, and latches its request fields.
Drives the L1.5 header handshake, tracks the one outstanding transaction, and routes the L1.5 response back to the owning requester.
Interrupt returns (INT_RET) bypass the state machine and are signalled on a dedicated strobe.

Parameters:
ADDR_WIDTH, 40, width of L1.5 physical address (matches PHY_ADDR_WIDTH)
RESP_TIMEOUT, 1023, cycles in WAIT before timeout_err is set; counter width = clog2(RESP_TIMEOUT+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous active-low
mem_req_val  in  1  mem requester has a request
mem_req_rqtype  in  5  LOAD_RQ/STORE_RQ
mem_req_size  in  3  PCX size code
mem_req_addr  in  ADDR_WIDTH  physical address
mem_req_data  in  64  store data
mem_req_nc  in  1  non-cacheable
mem_req_ready  out  1  request accepted (1-cycle pulse)
io_req_val, io_req_rqtype, io_req_size, io_req_addr, io_req_data, io_req_nc, io_req_ready  same as mem_*, for the io requester
transducer_l15_val  out  1  request valid to L1.5
transducer_l15_rqtype  out  5  latched rqtype
transducer_l15_size  out  3  latched size
transducer_l15_address  out  ADDR_WIDTH  latched address
transducer_l15_data  out  64  latched data
transducer_l15_nc  out  1  latched nc
l15_transducer_header_ack  in  1  L1.5 accepted request header
l15_transducer_val  in  1  L1.5 response valid
l15_transducer_returntype  in  4  LOAD_RET/ST_ACK/INT_RET/other
l15_transducer_data_0, l15_transducer_data_1  in  64 each  response data
transducer_l15_req_ack  out  1  response consumed
resp_data_0, resp_data_1  out  64 each  combinational pass-through of response data
mem_resp_val  out  1  response for mem requester (1-cycle)
io_resp_val  out  1  response for io requester (1-cycle)
int_val  out  1  INT_RET with data_0[17:16]==2'b01 (1-cycle)
timeout_err  out  1  sticky response timeout
spurious_err  out  1  sticky non-INT response received outside WAIT

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr_ptr=mem; owner=mem; latched fields=0; watchdog=0; every output listed above=0 except resp_data_* (pass-through).
- States: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - Only mem_req_val=1: grant mem.
  - Only io_req_val=1: grant io.
  - Both valid: grant the side rr_ptr points to.
- IDLE, on grant: latch rqtype/size/addr/data/nc and set owner to the granted side; pulse that side's *_req_ready in the same cycle (transfer = val&ready); next state ISSUE.
- ISSUE: transducer_l15_val=1, all fields held stable. When header_ack=1: next state WAIT, and transducer_l15_val drops the following cycle. No timeout applies in ISSUE.
- WAIT, response handling:
  - l15_transducer_val & returntype∈{LOAD_RET, ST_ACK}: in that same cycle pulse owner's *_resp_val and transducer_l15_req_ack.
  - Next state IDLE; rr_ptr = the non-owner side.
  - A new grant is possible in the next cycle, so back-to-back throughput is one request per 3+ cycles.
- WAIT, watchdog: increments each cycle, saturates. At RESP_TIMEOUT it sets timeout_err, which holds until reset. The FSM keeps waiting. Watchdog clears on leaving WAIT.
- INT_RET, any state: transducer_l15_req_ack=1 the same cycle; int_val=1 only if data_0[17:16]==2'b01. No state change, and never routed to a requester.
- Other returntypes in WAIT: acked the same cycle and dropped; state unchanged.
- Non-INT response in IDLE/ISSUE: acked and dropped; spurious_err sticky set.
- *_req_ready is never asserted outside IDLE; a requester must hold its val and fields until ready.
- At most one of mem_resp_val/io_resp_val is high per cycle.
- Reset asserted mid-transaction aborts it: no resp_val is generated, and any later L1.5 response is treated as spurious.

Test Plan:
- Mem only: mem_req_val=1 with addr=0x80_0000_0040, LOAD_RQ. Required: mem_req_ready pulses cycle 0; transducer_l15_val=1 from cycle 1 with that address; header_ack at cycle 3 makes val drop at cycle 4; LOAD_RET at cycle 6 gives mem_resp_val=1, req_ack=1, resp_data_0 equal to input.
- Both valid from reset: mem granted first, then io; with both held, grants alternate mem,io,mem,io over 4 transactions.
- INT_RET with data_0[17:16]=01 arriving during WAIT of an io load: int_val=1 and req_ack=1 that cycle; state stays WAIT. A later LOAD_RET gives io_resp_val=1.
- No response after header_ack: timeout_err=1 exactly RESP_TIMEOUT cycles after entering WAIT. A subsequent ST_ACK still completes the transaction to the owner.
- ST_ACK while IDLE: req_ack=1 and spurious_err=1; mem_resp_val=0 and io_resp_val=0.
- rst_n asserted in ISSUE: transducer_l15_val=0 immediately (async); after release, state=IDLE and rr_ptr=mem.
